// File: rtl/ysyx_25020047_commit.sv
// ----------------------------------------------------------------------------
// ysyx_25020047_commit
//
// Commit stage: the receiving end of the write-back interface. It owns the
// architectural state written by retiring instructions and accepts one
// instruction per valid/ready handshake.
//
// Architectural state held here:
//   - NR_GPR x 32-bit general purpose register file, x0 hardwired to zero
//   - PC register (loaded with RESET_PC on reset)
//   - 64-bit retired-instruction counter
//   - halt flag and the a0 (x10) exit code captured when ebreak retires
//
// Handshake: the write-back stage presents an instruction with wb_valid
// high. wb_ready is high while the core is running and low once halted. An
// instruction commits on a rising clk edge where wb_valid && wb_ready and
// rst is low. wb_ready never depends on wb_valid, so it is safe for the
// producer to look at wb_ready before deciding to raise wb_valid.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   wb_valid/ready    write-back handshake
//   wb_wen, wb_rd,
//   wb_wdata          GPR write request of the retiring instruction
//   wb_dnpc           next PC of the retiring instruction
//   wb_ebreak         retiring instruction is ebreak (halts the core)
//   rs1_addr/data,
//   rs2_addr/data     combinational read ports with write-through bypass
//   pc, retired       architectural PC and retired-instruction count
//   halted, halt_code halt flag and a0 value captured at halt
// ----------------------------------------------------------------------------
module ysyx_25020047_commit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NR_GPR   = 32,
    localparam int         AW       = $clog2(NR_GPR)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic          wb_wen,
    input  logic [AW-1:0] wb_rd,
    input  logic [31:0]   wb_wdata,
    input  logic [31:0]   wb_dnpc,
    input  logic          wb_ebreak,

    input  logic [AW-1:0] rs1_addr,
    output logic [31:0]   rs1_data,
    input  logic [AW-1:0] rs2_addr,
    output logic [31:0]   rs2_data,

    output logic [31:0]   pc,
    output logic [63:0]   retired,
    output logic          halted,
    output logic [31:0]   halt_code
);

    // a0 holds the program exit code by the RISC-V calling convention.
    localparam logic [AW-1:0] A0_IDX = AW'(10);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e        state_q,     state_d;
    logic [31:0]   pc_q,        pc_d;
    logic [63:0]   retired_q,   retired_d;
    logic [31:0]   halt_code_q, halt_code_d;
    logic [31:0]   gpr_q [NR_GPR];
    logic [31:0]   gpr_d [NR_GPR];

    logic          commit;
    logic          gpr_we;
    logic          bypass_en;
    logic [31:0]   a0_after_commit;

    // ------------------------------------------------------------------------
    // Handshake and write enables
    // ------------------------------------------------------------------------
    assign wb_ready = (state_q == ST_RUN);
    assign commit   = wb_valid && wb_ready;
    // Writes to x0 are dropped here so gpr_q[0] never leaves zero.
    assign gpr_we   = commit && wb_wen && (wb_rd != '0);
    // A commit in the reset cycle is discarded, so it must not be forwarded
    // to the read ports either.
    assign bypass_en = gpr_we && !rst;

    // The exit code is the a0 value as seen after this instruction's own
    // write, so an ebreak that also writes a0 reports the new value.
    assign a0_after_commit = (gpr_we && (wb_rd == A0_IDX)) ? wb_wdata
                                                           : gpr_q[A0_IDX];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        halt_code_d = halt_code_q;
        for (int i = 0; i < NR_GPR; i++) begin
            gpr_d[i] = gpr_q[i];
        end

        if (commit) begin
            pc_d      = wb_dnpc;
            retired_d = retired_q + 64'd1;  // wraps modulo 2^64
            if (gpr_we) begin
                gpr_d[wb_rd] = wb_wdata;
            end
            if (wb_ebreak) begin
                state_d     = ST_HALT;
                halt_code_d = a0_after_commit;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers; reset wins over any concurrent handshake.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            retired_q   <= 64'd0;
            halt_code_q <= 32'd0;
            for (int i = 0; i < NR_GPR; i++) begin
                gpr_q[i] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            halt_code_q <= halt_code_d;
            for (int i = 0; i < NR_GPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: x0 reads zero; a same-cycle write to the addressed register
    // is forwarded so decode sees the value being retired right now.
    // ------------------------------------------------------------------------
    always_comb begin
        rs1_data = 32'd0;
        if (rs1_addr != '0) begin
            if (bypass_en && (wb_rd == rs1_addr)) begin
                rs1_data = wb_wdata;
            end else begin
                rs1_data = gpr_q[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = 32'd0;
        if (rs2_addr != '0) begin
            if (bypass_en && (wb_rd == rs2_addr)) begin
                rs2_data = wb_wdata;
            end else begin
                rs2_data = gpr_q[rs2_addr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered architectural outputs
    // ------------------------------------------------------------------------
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign halted    = (state_q == ST_HALT);
    assign halt_code = halt_code_q;

endmodule

// File: tb/tb_ysyx_25020047_commit.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_25020047_commit.
// Inputs change 1 ns after a rising edge; combinational read ports are
// sampled 2 ns later, registered outputs 1 ns after the following edge.
// The reference model keeps the architectural state as plain variables and
// applies each cycle's effect as a whole instruction.
// ----------------------------------------------------------------------------
module tb_ysyx_25020047_commit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic [31:0] wb_dnpc;
    logic        wb_ebreak;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [63:0] retired;
    logic        halted;
    logic [31:0] halt_code;

    ysyx_25020047_commit dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_wen    (wb_wen),
        .wb_rd     (wb_rd),
        .wb_wdata  (wb_wdata),
        .wb_dnpc   (wb_dnpc),
        .wb_ebreak (wb_ebreak),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .pc        (pc),
        .retired   (retired),
        .halted    (halted),
        .halt_code (halt_code)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_gpr [32];
    logic [31:0] m_pc;
    logic [63:0] m_ret;
    logic        m_halted;
    logic [31:0] m_code;

    // scoreboard: expected PC after every edge
    logic [31:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_pc     = 32'h8000_0000;
        m_ret    = 64'd0;
        m_halted = 1'b0;
        m_code   = 32'd0;
    endtask

    // Value the core should present on a read port this cycle.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic fire,
                                             input logic wen, input logic [4:0] rd,
                                             input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (fire && wen && rd == a) return wd;
        return m_gpr[a];
    endfunction

    // ---------------- driver: one full clock cycle ----------------
    task automatic cycle(input logic v, input logic wen, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [31:0] dnpc,
                         input logic eb, input logic r,
                         input logic [4:0] a1, input logic [4:0] a2);
        logic fire;
        rst = r; wb_valid = v; wb_wen = wen; wb_rd = rd; wb_wdata = wd;
        wb_dnpc = dnpc; wb_ebreak = eb; rs1_addr = a1; rs2_addr = a2;
        #2;
        fire = v && !m_halted && !r;
        check("wb_ready", wb_ready, !m_halted);
        check("rs1_data", rs1_data, exp_read(a1, fire, wen, rd, wd));
        check("rs2_data", rs2_data, exp_read(a2, fire, wen, rd, wd));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (fire) begin
            m_pc  = dnpc;
            m_ret = m_ret + 64'd1;
            if (wen && rd != 5'd0) m_gpr[rd] = wd;
            if (eb) begin
                m_halted = 1'b1;
                m_code   = m_gpr[10];
            end
        end
        exp_q.push_back(m_pc);
        #1;
        check("pc", pc, exp_q.pop_front());
        check("retired", retired, m_ret);
        check("halted", halted, m_halted);
        check("halt_code", halt_code, m_code);
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, a1, a2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0]  r_rd;
        logic [31:0] r_wd;
        rst = 1'b1; wb_valid = 1'b0; wb_wen = 1'b0; wb_rd = '0; wb_wdata = '0;
        wb_dnpc = '0; wb_ebreak = 1'b0; rs1_addr = '0; rs2_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // reset then idle; sweep every read address
        repeat (3) idle(5'd0, 5'd0);
        check("reset_pc", pc, 32'h8000_0000);
        check("reset_retired", retired, 64'd0);
        check("reset_halted", halted, 1'b0);
        check("reset_ready", wb_ready, 1'b1);
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        // commit to x5 with bypass on rs1
        cycle(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h8000_0004, 1'b0, 1'b0, 5'd5, 5'd5);
        check("c1_pc", pc, 32'h8000_0004);
        check("c1_retired", retired, 64'd1);
        wb_valid = 1'b0; rs1_addr = 5'd5; #1;
        check("gpr5_readback", rs1_data, 32'hDEAD_BEEF);

        // commit to x0 is discarded, pc/retired still advance
        cycle(1'b1, 1'b1, 5'd0, 32'h0000_1234, 32'h8000_0008, 1'b0, 1'b0, 5'd0, 5'd5);
        check("x0_pc", pc, 32'h8000_0008);
        check("x0_retired", retired, 64'd2);
        wb_valid = 1'b0; rs1_addr = 5'd0; #1;
        check("x0_readback", rs1_data, 32'd0);

        // two commits separated by 4 idle cycles, from fresh reset
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0);
        cycle(1'b1, 1'b1, 5'd3, 32'h0000_0033, 32'h8000_0004, 1'b0, 1'b0, 5'd3, 5'd1);
        repeat (4) idle(5'd3, 5'd5);
        check("gap_pc_hold", pc, 32'h8000_0004);
        cycle(1'b1, 1'b1, 5'd4, 32'h0000_0044, 32'h8000_0008, 1'b0, 1'b0, 5'd4, 5'd3);
        check("gap_retired", retired, 64'd2);

        // ebreak writing a0 = 7
        cycle(1'b1, 1'b1, 5'd10, 32'd7, 32'h8000_000C, 1'b1, 1'b0, 5'd10, 5'd10);
        check("ebreak_halted", halted, 1'b1);
        check("ebreak_code", halt_code, 32'd7);
        check("ebreak_ready", wb_ready, 1'b0);
        repeat (3) cycle(1'b1, 1'b1, 5'd10, $urandom, $urandom, 1'b0, 1'b0, 5'd10, 5'd4);
        check("halt_pc_hold", pc, 32'h8000_000C);
        check("halt_retired_hold", retired, 64'd3);

        // reset while halted with a valid instruction presented
        cycle(1'b1, 1'b1, 5'd10, 32'h0000_0099, 32'h9000_0000, 1'b1, 1'b1, 5'd10, 5'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_retired", retired, 64'd0);
        check("rst_halted", halted, 1'b0);
        wb_valid = 1'b0; rs1_addr = 5'd10; #1;
        check("rst_gpr10", rs1_data, 32'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic r;
            r_rd = 5'($urandom_range(0, 31));
            r_wd = $urandom;
            r = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, r_rd, r_wd,
                  $urandom, $urandom_range(0, 39) == 0, r,
                  $urandom_range(0, 1) ? r_rd : 5'($urandom_range(0, 31)),
                  $urandom_range(0, 2) == 0 ? r_rd : 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_commit.md
Name: ysyx_25020047_commit

Overview:
- Receiving end of the write-back interface: accepts one retiring instruction per handshake from the write-back stage (write data, destination register, next PC).
- Owns the architectural state that write-back targets: the 32x32 GPR file with x0 hardwired to zero, the PC register, and a retired-instruction counter.
- Serves two combinational read ports to decode/execute.
- Handles the ebreak halt so the simulation harness can stop and read the exit code from a0.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NR_GPR, 32, number of GPRs (power of two; rd/rs index width is log2(NR_GPR)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_valid  input  1  write-back presents a retiring instruction.
- wb_ready  output  1  commit can accept this cycle.
- wb_wen  input  1  instruction writes a GPR.
- wb_rd  input  5  destination register index.
- wb_wdata  input  32  value to write to rd.
- wb_dnpc  input  32  next PC of the retiring instruction.
- wb_ebreak  input  1  retiring instruction is ebreak.
- rs1_addr  input  5  read port 1 index.
- rs1_data  output  32  read port 1 data.
- rs2_addr  input  5  read port 2 index.
- rs2_data  output  32  read port 2 data.
- pc  output  32  current architectural PC.
- retired  output  64  count of committed instructions.
- halted  output  1  core has executed ebreak.
- halt_code  output  32  a0 (x10) value captured at halt.

Behaviour:
- States: RUN, HALT. Reset enters RUN. There are no other states.
- wb_ready = 1 in RUN and 0 in HALT.
- Commit occurs on a rising edge where wb_valid & wb_ready.
- On commit:
  - pc <= wb_dnpc.
  - retired <= retired + 1, wrapping modulo 2^64.
  - If wb_wen and wb_rd != 0: GPR[wb_rd] <= wb_wdata.
  - Writes to x0 are discarded silently.
- Commit with wb_ebreak = 1:
  - The GPR write and PC update still occur.
  - retired still increments.
  - State goes to HALT; halted <= 1.
  - halt_code <= the a0 value after this commit's write. If this instruction writes x10, halt_code equals wb_wdata.
- wb_valid = 0 in RUN: no state changes.
- HALT:
  - No commit.
  - pc, GPRs, retired, halt_code all hold.
  - The only exit is rst.
  - wb_valid is ignored.
- Reset (any state, including mid-handshake):
  - pc = RESET_PC, retired = 0, halted = 0, halt_code = 0, state = RUN.
  - All GPRs cleared to 0.
  - A wb_valid in the same cycle as rst is not committed.
- Read ports:
  - Combinational. Address 0 always returns 0.
  - Bypass: if a commit writing register r (r != 0) happens this cycle and rsN_addr == r, rsN_data = wb_wdata (write-through). Otherwise rsN_data returns the stored value.
  - Both ports may address the same register simultaneously.
- pc, retired, halted and halt_code are registered outputs. They change only on clock edges.
- No X propagation: every output is defined from the first cycle after reset.

Test Plan:
- Reset then idle 3 cycles -> pc = 32'h8000_0000, retired = 0, halted = 0, wb_ready = 1, rs1_data = rs2_data = 0 for every address.
- Commit wen = 1, rd = 5, wdata = 32'hDEAD_BEEF, dnpc = 32'h8000_0004, with rs1_addr = 5 in the same cycle -> rs1_data = DEADBEEF combinationally (bypass); next cycle pc = 80000004, retired = 1, GPR5 readback = DEADBEEF.
- Commit wen = 1, rd = 0, wdata = 32'h1234 -> rs1_addr = 0 reads 0 both during and after the commit; pc and retired still advance.
- Hold wb_valid = 0 for 4 cycles between two commits -> pc and retired change only at the two commit edges; retired ends at 2.
- Commit rd = 10, wdata = 7 with wb_ebreak = 1 -> next cycle halted = 1, halt_code = 7, wb_ready = 0; further wb_valid pulses leave pc and retired unchanged.
- Assert rst while halted and with wb_valid = 1 -> next cycle state is RUN, pc = 80000000, retired = 0, GPR10 = 0, halted = 0; no commit from the rst cycle.
